// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: multiply/divide opcodes and sequencer states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } muldiv_state_t;

    function automatic logic isSignedOp(input muldiv_op_t o);
        return (o == MULT) || (o == DIV);
    endfunction

    function automatic logic isDivOp(input muldiv_op_t o);
        return (o == DIV) || (o == DIVU);
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
//   state | meaning
//   IDLE  | waiting for start; hi/lo hold last result
//   CALC  | one shift-add / restoring-divide step per cycle, WIDTH steps
//   FIN   | sign correction, hi/lo load, done registered for next cycle
module execute_muldiv
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    muldiv_state_t    state, nextState;
    muldiv_op_t       opReg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] mag;
    logic             negLo, negHi, divZero;

    logic             accept, finish;
    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   mulSum, remShift, trial;
    logic [2*WIDTH-1:0] prodMag, prodRes;
    logic [WIDTH-1:0] quotRes, remRes;

    assign accept = (state == IDLE) && start && !flush;
    assign finish = (state == FIN) && !flush;
    assign busy   = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CALC;
            CALC:    if (cnt == LAST_CNT) nextState = FIN;
            FIN:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (flush) nextState = IDLE;
    end

    assign absA = (isSignedOp(op) && opA[WIDTH-1]) ? -opA : opA;
    assign absB = (isSignedOp(op) && opB[WIDTH-1]) ? -opB : opB;

    // acc[WIDTH] stays zero during multiply; summing the full width keeps the carry
    assign mulSum   = acc + (low[0] ? {1'b0, mag} : '0);
    assign remShift = {acc[WIDTH-1:0], low[WIDTH-1]};
    assign trial    = remShift - {1'b0, mag};

    assign prodMag = {acc[WIDTH-1:0], low};
    assign prodRes = negLo ? -prodMag : prodMag;
    assign quotRes = negLo ? -low : low;
    assign remRes  = negHi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            opReg   <= MULT;
            cnt     <= '0;
            acc     <= '0;
            low     <= '0;
            mag     <= '0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            if (accept) begin
                opReg   <= op;
                cnt     <= '0;
                acc     <= '0;
                low     <= absA;
                mag     <= absB;
                negLo   <= isSignedOp(op) && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                negHi   <= isSignedOp(op) && opA[WIDTH-1];
                divZero <= (opB == '0);
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
                if (isDivOp(opReg)) begin
                    if (!trial[WIDTH]) begin
                        acc <= trial;
                        low <= {low[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= remShift;
                        low <= {low[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc <= {1'b0, mulSum[WIDTH:1]};
                    low <= {mulSum[0], low[WIDTH-1:1]};
                end
            end

            // A zero divisor leaves the dividend magnitude in the remainder,
            // so its sign-corrected form already equals opA
            if (finish) begin
                if (isDivOp(opReg)) begin
                    hi <= remRes;
                    lo <= divZero ? '1 : quotRes;
                end else begin
                    hi <= prodRes[2*WIDTH-1:WIDTH];
                    lo <= prodRes[WIDTH-1:0];
                end
            end
            done <= finish;
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed-vector bench for execute_muldiv at WIDTH=32.
module tb_execute_muldiv;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic        start;
    muldiv_op_t  op;
    logic [31:0] opA, opB;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int passes = 0;

    execute_muldiv #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .start(start), .op(op),
        .opA(opA), .opB(opB), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        op = o; opA = a; opB = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge CLK); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic countDone(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
            if (done) seen++;
        end
    endtask

    task automatic runOp(input string tag, input muldiv_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        int lat;
        issue(o, a, b);
        checkEq({tag, " busy"}, 64'(busy), 64'd1);
        waitDone(lat);
        checkEq({tag, " latency"}, 64'(lat), 64'd33);
        checkEq({tag, " hi"}, 64'(hi), 64'(expHi));
        checkEq({tag, " lo"}, 64'(lo), 64'(expLo));
        @(posedge CLK); #1;
        checkEq({tag, " done width"}, 64'(done), 64'd0);
        checkEq({tag, " lo held"}, 64'(lo), 64'(expLo));
    endtask

    initial begin
        int lat, seen;
        RST = 1'b1; flush = 1'b0; start = 1'b0; op = MULT; opA = '0; opB = '0;
        repeat (2) @(posedge CLK);
        #1;
        checkEq("reset busy", 64'(busy), 64'd0);
        checkEq("reset done", 64'(done), 64'd0);
        checkEq("reset hi", 64'(hi), 64'd0);
        checkEq("reset lo", 64'(lo), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        runOp("mult neg", MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        runOp("multu max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        runOp("mult pos neg", MULT, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC);
        runOp("multu big", MULTU, 32'h80000000, 32'h00000003, 32'h00000001, 32'h80000000);
        runOp("divu 100/7", DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
        runOp("div -7/2", DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("div 7/-2", DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        runOp("div min/-1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        runOp("divu by zero", DIVU, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF);
        runOp("div neg by zero", DIV, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF);
        runOp("divu big", DIVU, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF);

        // start while busy must be dropped, not queued
        issue(MULTU, 32'd6, 32'd7);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        op = DIVU; opA = 32'd100; opB = 32'd7; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        waitDone(lat);
        checkEq("ignored start latency", 64'(lat + 5), 64'd33);
        checkEq("ignored start hi", 64'(hi), 64'd0);
        checkEq("ignored start lo", 64'(lo), 64'd42);
        countDone(40, seen);
        checkEq("ignored start no queue", 64'(seen), 64'd0);

        // flush in CALC cycle 10
        issue(MULT, 32'hFFFFFFFD, 32'h00000007);
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        checkEq("flush busy", 64'(busy), 64'd0);
        countDone(40, seen);
        checkEq("flush no done", 64'(seen), 64'd0);
        checkEq("flush hi kept", 64'(hi), 64'd0);
        checkEq("flush lo kept", 64'(lo), 64'd42);

        // flush beats start in the same cycle
        @(negedge CLK);
        op = MULTU; opA = 32'd2; opB = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; flush = 1'b0;
        checkEq("flush over start busy", 64'(busy), 64'd0);

        // flush in FIN: no done, no load
        issue(MULTU, 32'd3, 32'd3);
        repeat (32) @(posedge CLK);
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        checkEq("fin flush done", 64'(done), 64'd0);
        checkEq("fin flush lo kept", 64'(lo), 64'd42);

        // reset mid-CALC
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        checkEq("rst busy", 64'(busy), 64'd0);
        checkEq("rst hi", 64'(hi), 64'd0);
        checkEq("rst lo", 64'(lo), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        countDone(40, seen);
        checkEq("rst no done", 64'(seen), 64'd0);

        runOp("after rst", DIV, 32'd100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
